seq_alu: RTL and testbench

Parametrised, handshaked successor to the 32-bit combinational ALU. It executes single-cycle ops (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR, SLTU) with a registered result, and an optional iterative shift-add multiply. Operands enter through a valid/ready port and leave through a one-entry result register with its own valid/ready port. It sits between operand fetch and writeback in the lab CPU datapath.

---
 rtl/seq_alu.sv | 206 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with optional iterative shift-add multiply
//
// Purpose: executes single-cycle ops (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR,
// SLTU) into a one-entry result register. When SEQ_ALU_MUL_EN is defined, it
// also runs a WIDTH-cycle unsigned shift-add multiply. When the macro is
// undefined, op 1000 is handled like any reserved op.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   operand transaction offered
//   in_ready   block can accept (combinational)
//   a, b, op   operands and opcode, sampled on acceptance only
//   out_valid  result register full
//   out_ready  consumer takes result
//   out        result
//   cout, zero, overflow, err  result flags, registered with out

module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    // Single-cycle datapath: one shared adder serves ADD, SUB and SLT.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;

    always_comb begin
        is_sub  = (op == OP_SUB) || (op == OP_SLT);
        b_eff   = is_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_comb begin
        alu_out  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_out  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_XOR:  alu_out = a ^ b;
            // N ^ V of a-b gives the true signed order even when a-b overflows.
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            OP_AND:  alu_out = a & b;
            OP_NAND: alu_out = ~(a & b);
            OP_NOR:  alu_out = ~(a | b);
            OP_OR:   alu_out = a | b;
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, a < b};
            default: alu_err = 1'b1;
        endcase
    end

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] ld_out;
    logic             ld_cout;
    logic             ld_ovf;
    logic             ld_err;

    assign accept = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    // High half accumulates partial sums; low half starts as the multiplier
    // and is shifted out one bit per cycle as product bits shift in.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     partial;
    logic               is_mul;
    logic               mul_last;

    always_comb begin
        is_mul    = (op == OP_MUL);
        mul_last  = (count == CW'(WIDTH - 1));
        partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_step = {partial, prod[WIDTH-1:1]};
    end

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !reset;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_next = S_MUL;
            S_MUL:   if (mul_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            mcand <= '0;
            prod  <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) begin
                if (accept && is_mul) begin
                    mcand <= a;
                    prod  <= {{WIDTH{1'b0}}, b};
                    count <= '0;
                end
            end else begin
                prod  <= prod_step;
                count <= mul_last ? '0 : count + 1'b1;
            end
        end
    end

    always_comb begin
        load    = 1'b0;
        ld_out  = alu_out;
        ld_cout = alu_cout;
        ld_ovf  = alu_ovf;
        ld_err  = alu_err;
        if (state == S_MUL) begin
            load    = mul_last;
            ld_out  = prod_step[WIDTH-1:0];
            ld_cout = 1'b0;
            ld_ovf  = |prod_step[2*WIDTH-1:WIDTH];
            ld_err  = 1'b0;
        end else begin
            load = accept && !is_mul;
        end
    end
`else
    assign in_ready = (!out_valid || out_ready) && !reset;

    always_comb begin
        load    = accept;
        ld_out  = alu_out;
        ld_cout = alu_cout;
        ld_ovf  = alu_ovf;
        ld_err  = alu_err;
    end
`endif

    // Result register: a new load in the same cycle as a drain keeps it full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out       <= ld_out;
            cout      <= ld_cout;
            zero      <= (ld_out == '0);
            overflow  <= ld_ovf;
            err       <= ld_err;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard testbench for seq_alu (WIDTH=32)

module tb_seq_alu;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_R15  = 4'd15;

    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        cout;
    logic        zero;
    logic        overflow;
    logic        err;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .zero      (zero),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    // flags packed as {err, overflow, zero, cout}
    typedef struct packed {
        logic [31:0] o;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   rand_on;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] o, input logic [3:0] f);
        exp_t e;
        e.o = o;
        e.f = f;
        return e;
    endfunction

    // Independent reference built on 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      sr;
        logic [63:0] u;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        e;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        e  = 1'b0;
        case (o)
            OP_ADD: begin
                u  = {32'd0, x} + {32'd0, y};
                r  = u[31:0];
                c  = u[32];
                sr = sx + sy;
                v  = (sr > SMAX) || (sr < SMIN);
            end
            OP_SUB: begin
                u  = {32'd0, x} + {32'd0, ~y} + 64'd1;
                r  = u[31:0];
                c  = u[32];
                sr = sx - sy;
                v  = (sr > SMAX) || (sr < SMIN);
            end
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
            OP_AND:  r = x & y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_OR:   r = x | y;
            OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                u = {32'd0, x} * {32'd0, y};
                r = u[31:0];
                v = |u[63:32];
            end
`endif
            default: e = 1'b1;
        endcase
        return mk(r, {e, v, (r == 32'd0), c});
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("out", 64'(out), 64'(e.o));
                check_val("flags", 64'({err, overflow, zero, cout}), 64'(e.f));
            end
        end
    end

    // Entered and left at posedge+1; holds in_valid until accepted.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (in_ready) sb.push_back(e);
        else check_val("issue_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int   bp_bad;
        int   lat;
        int   irdy_bad;
        logic [3:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b0;
        rand_on   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out", 64'(out), 64'd0);
        check_val("rst_flags", 64'({err, overflow, zero, cout}), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        issue(OP_ADD, 32'd2, 32'd3, mk(32'd5, 4'b0000));
        check_val("lat1_valid", 64'(out_valid), 64'd1);

        vecs = '{
            '{OP_ADD,  32'h000F_FFFF, 32'h0000_0001, 32'h0010_0000, 4'b0000},
            '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0011},
            '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0100},
            '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0011},
            '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0000},
            '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0101},
            '{OP_SLT,  32'h8000_0008, 32'h0000_0002, 32'h0000_0001, 4'b0000},
            '{OP_SLT,  32'h0000_0008, 32'h8000_0002, 32'h0000_0000, 4'b0010},
            '{OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0000},
            '{OP_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 4'b0010},
            '{OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000},
            '{OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0010},
            '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000},
            '{OP_OR,   32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000},
            '{OP_XOR,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b0010},
            '{OP_R15,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1010}
        };
        foreach (vecs[i]) issue(vecs[i].o, vecs[i].x, vecs[i].y, mk(vecs[i].r, vecs[i].f));
        drain();

        // Backpressure: result must hold and block further acceptance.
        out_ready = 1'b0;
        issue(OP_XOR, 32'd0, 32'd1, mk(32'd1, 4'b0000));
        in_valid = 1'b1;
        op       = OP_ADD;
        a        = 32'd2;
        b        = 32'd2;
        bp_bad   = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out !== 32'd1 || in_ready !== 1'b0) bp_bad++;
        end
        check_val("bp_hold", 64'(bp_bad), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(OP_ADD, 32'd2, 32'd2, mk(32'd4, 4'b0000));
        issue(OP_OR,  32'd8, 32'd1, mk(32'd9, 4'b0000));
        issue(OP_SUB, 32'd9, 32'd4, mk(32'd5, 4'b0001));
        drain();

`ifdef SEQ_ALU_MUL_EN
        issue(OP_MUL, 32'd7, 32'd6, mk(32'd42, 4'b0000));
        lat      = 0;
        irdy_bad = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = e;
                break;
            end
            if (in_ready) irdy_bad++;
        end
        check_val("mul_latency", 64'(lat), 64'd32);
        check_val("mul_in_ready_low", 64'(irdy_bad), 64'd0);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, mk(32'd0, 4'b0110));
        drain();
`else
        issue(OP_MUL, 32'd7, 32'd6, mk(32'd0, 4'b1010));
        check_val("op8_rsv_latency", 64'(out_valid), 64'd1);
        drain();
`endif

        // Reset partway through a multiply (single-cycle reserved op otherwise).
        issue(OP_MUL, 32'd5, 32'd7, model(OP_MUL, 32'd5, 32'd7));
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_out", 64'(out), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(OP_ADD, 32'd2, 32'd3, mk(32'd5, 4'b0000));
        check_val("post_rst_valid", 64'(out_valid), 64'd1);
        check_val("post_rst_out", 64'(out), 64'd5);
        drain();

        // Random traffic with random consumer stalls.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    ro = 4'($urandom_range(0, 15));
                    rx = $urandom;
                    ry = (i % 4 == 0) ? rx : $urandom;
                    issue(ro, rx, ry, model(ro, rx, ry));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
